// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scanner: state encoding, channel count, select width.
// Pure declarations; no timing or backpressure of its own.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  localparam int CH_N  = 4;
  localparam int SEL_W = 2;

  // Settle counter only needs to reach SETTLE-1, so clog2(SETTLE+1) bits cover it.
  function automatic int cnt_w(input int settle);
    return $clog2(settle + 1);
  endfunction

endpackage

// File: rtl/mux_scan_if.sv
// Scanner-facing bundle: scan handshake (start/busy/done/data) plus mux controls (c/g) and mux output y.
// cont exists only when MUX_SCAN_CONT_EN is defined; master is the scanner side, slave the environment side.
interface mux_scan_if;
  import mux_scan_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic              g;
  logic [SEL_W-1:0]  c;
  logic              y;
  logic [CH_N-1:0]   data;

`ifdef MUX_SCAN_CONT_EN
  logic              cont;

  modport master (
    input  start,
    input  y,
    input  cont,
    output busy,
    output done,
    output g,
    output c,
    output data
  );

  modport slave (
    output start,
    output y,
    output cont,
    input  busy,
    input  done,
    input  g,
    input  c,
    input  data
  );
`else
  modport master (
    input  start,
    input  y,
    output busy,
    output done,
    output g,
    output c,
    output data
  );

  modport slave (
    output start,
    output y,
    input  busy,
    input  done,
    input  g,
    input  c,
    input  data
  );
`endif

endinterface

// File: rtl/mux_scan_settle.sv
// Settle timer: counts while enabled, clears on request, flags the cycle where count reaches SETTLE-1.
// Zero-latency combinational expire from the registered count; no backpressure.
module mux_scan_settle
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
)
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = cnt_w(SETTLE);

  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("mux_scan_settle: SETTLE must be in 1..15");
    end
  endgenerate

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_expire = (r_cnt == CW'(SETTLE - 1));

endmodule

// File: rtl/mux_scan.sv
// mux_scan: drives C/G of a 4:1 mux, samples Y per channel after SETTLE cycles, publishes DATA with a DONE pulse.
// Latency 4*(SETTLE+1)+1 cycles from START; START ignored while BUSY; MUX_SCAN_CONT_EN adds CONT for back-to-back scans.
module mux_scan
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 2
)
(
  input  logic       i_clk,
  input  logic       i_rst,
  mux_scan_if.master io_scan
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH_N - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_g;
  logic              w_g_nxt;
  logic [SEL_W-1:0]  r_c;
  logic [SEL_W-1:0]  w_c_nxt;
  logic [CH_N-1:0]   r_data;
  logic [CH_N-1:0]   w_data_nxt;
  logic [CH_N-2:0]   r_shadow;
  logic [CH_N-2:0]   w_shadow_nxt;
  logic              w_tmr_en;
  logic              w_tmr_clr;
  logic              w_expire;

  // Timer runs only in SETTLE; every other state holds it at zero so each channel starts fresh.
  assign w_tmr_en  = (r_state == ST_SETTLE);
  assign w_tmr_clr = ~w_tmr_en;

  mux_scan_settle #(
    .SETTLE   (SETTLE)
  ) u_settle (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_tmr_clr),
    .i_en     (w_tmr_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_g      <= 1'b1;
      r_c      <= '0;
      r_data   <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_g      <= w_g_nxt;
      r_c      <= w_c_nxt;
      r_data   <= w_data_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_g_nxt      = r_g;
    w_c_nxt      = r_c;
    w_data_nxt   = r_data;
    w_shadow_nxt = r_shadow;
    unique case (r_state)
      ST_IDLE: begin
        w_g_nxt = 1'b1;
        w_c_nxt = '0;
        if (io_scan.start) begin
          w_state_nxt = ST_SETTLE;
          w_g_nxt     = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (w_expire) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        // Last channel's Y goes straight into DATA so DATA moves exactly once per scan.
        if (r_c != LAST_CH) begin
          w_shadow_nxt[r_c] = io_scan.y;
          w_c_nxt           = r_c + SEL_W'(1);
          w_state_nxt       = ST_SETTLE;
        end else begin
          w_data_nxt  = {io_scan.y, r_shadow};
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
`ifdef MUX_SCAN_CONT_EN
        if (io_scan.cont) begin
          w_state_nxt = ST_SETTLE;
          w_c_nxt     = '0;
          w_g_nxt     = 1'b0;
        end else begin
          w_state_nxt = ST_IDLE;
          w_c_nxt     = '0;
          w_g_nxt     = 1'b1;
        end
`else
        w_state_nxt = ST_IDLE;
        w_c_nxt     = '0;
        w_g_nxt     = 1'b1;
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_c_nxt     = '0;
        w_g_nxt     = 1'b1;
      end
    endcase
  end

  assign io_scan.busy = (r_state != ST_IDLE);
  assign io_scan.done = (r_state == ST_FIN);
  assign io_scan.g    = r_g;
  assign io_scan.c    = r_c;
  assign io_scan.data = r_data;

  a_g_low_busy: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state != ST_IDLE) |-> !r_g);

  a_fin_last_ch: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_state == ST_FIN) |-> (r_c == LAST_CH));

endmodule

// File: tb/tb_mux_scan.sv
// Randomized scoreboard bench for mux_scan with a cycle-accurate behavioural mux and timing model.
// Honours MUX_SCAN_CONT_EN (SETTLE=1 and CONT stimulus when defined).
module tb_mux_scan;
  import mux_scan_pkg::*;

`ifdef MUX_SCAN_CONT_EN
  localparam int S = 1;
`else
  localparam int S = 2;
`endif
  localparam int L  = 4 * (S + 1);
  localparam int NE = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] x;
`ifdef MUX_SCAN_CONT_EN
  logic       cont_v;
`endif

  mux_scan_if bus();

  assign bus.y = bus.g ? 1'b0 : x[bus.c];

  mux_scan #(
    .SETTLE  (S)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .io_scan (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-edge values: index e describes the state just after rising edge e.
  logic [3:0] xs    [NE];
  logic       eg    [NE];
  logic       ebusy [NE];
  logic       edone [NE];
  logic       erst  [NE];
  logic [1:0] ec    [NE];

  typedef struct {
    int acc;
    int done_e;
  } rec_t;
  rec_t sbq[$];

  bit scan_on = 1'b0;
  int acc_e   = 0;
  int n_chk   = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, e, act, exp);
    end
  endtask

  // Drive inputs for the next rising edge and record what the spec says must follow it.
  task automatic step(input logic r, input logic s, input logic [3:0] xv);
    int e;
    int n;
    e = cyc + 1;
    rst       = r;
    bus.start = s;
    x         = xv;
`ifdef MUX_SCAN_CONT_EN
    bus.cont  = cont_v;
`endif
    if (e < NE) begin
      xs[e]   = xv;
      erst[e] = r;
      if (r) begin
        scan_on = 1'b0;
        sbq.delete();
      end else if (scan_on) begin
        if (e - acc_e + 1 == L + 2) begin
          scan_on = 1'b0;
`ifdef MUX_SCAN_CONT_EN
          if (cont_v) begin
            scan_on = 1'b1;
            acc_e   = e;
            sbq.push_back('{acc: e, done_e: e + L});
          end
`endif
        end
      end else if (s) begin
        scan_on = 1'b1;
        acc_e   = e;
        sbq.push_back('{acc: e, done_e: e + L});
      end
      if (scan_on) begin
        n        = e - acc_e + 1;
        eg[e]    = 1'b0;
        ebusy[e] = 1'b1;
        edone[e] = (n == L + 1);
        ec[e]    = (n == L + 1) ? 2'd3 : 2'((n - 1) / (S + 1));
      end else begin
        eg[e]    = 1'b1;
        ebusy[e] = 1'b0;
        edone[e] = 1'b0;
        ec[e]    = 2'd0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: compares controls every cycle, pops the scoreboard on each DONE.
  initial begin
    int         e;
    logic [3:0] exp_data;
    rec_t       rc;
    exp_data = 4'h0;
    forever begin
      @(posedge clk);
      #1;
      e = cyc;
      if (e > 0 && e < NE) begin
        chk("g", e, 32'(bus.g), 32'(eg[e]));
        chk("c", e, 32'(bus.c), 32'(ec[e]));
        chk("busy", e, 32'(bus.busy), 32'(ebusy[e]));
        chk("done", e, 32'(bus.done), 32'(edone[e]));
        if (erst[e]) exp_data = 4'h0;
        if (bus.done === 1'b1) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done edge=%0d got=done want=no_done", e);
          end else begin
            rc = sbq.pop_front();
            chk("done_edge", e, 32'(e), 32'(rc.done_e));
            for (int i = 0; i < 4; i++) begin
              if (rc.acc + (i + 1) * (S + 1) < NE)
                exp_data[i] = xs[rc.acc + (i + 1) * (S + 1)][i];
            end
          end
        end
        chk("data", e, 32'(bus.data), 32'(exp_data));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    x         = 4'h0;
`ifdef MUX_SCAN_CONT_EN
    cont_v    = 1'b0;
    bus.cont  = 1'b0;
`endif
    step(1'b1, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0);
    repeat (20) step(1'b0, 1'b0, 4'($urandom));

    // Basic scan
    step(1'b0, 1'b1, 4'b1010);
    repeat (L + 3) step(1'b0, 1'b0, 4'b1010);

    // START re-pulsed mid-scan and in the FIN cycle must be ignored
    step(1'b0, 1'b1, 4'b0110);
    for (int k = 1; k <= L + 4; k++) step(1'b0, (k == 5) || (k == L + 1), 4'b0110);
    step(1'b0, 1'b1, 4'b0110);
    repeat (L + 3) step(1'b0, 1'b0, 4'b0110);

    // Complete a scan of all ones, then reset in cycle 8 of the next one
    step(1'b0, 1'b1, 4'hF);
    repeat (L + 3) step(1'b0, 1'b0, 4'hF);
    step(1'b0, 1'b1, 4'hF);
    for (int k = 1; k <= 7; k++) step(1'b0, 1'b0, 4'hF);
    step(1'b1, 1'b0, 4'hF);
    repeat (4) step(1'b0, 1'b0, 4'hF);

    // X changes during settle of channel 2
    step(1'b0, 1'b1, 4'b0001);
    for (int k = 1; k <= L + 3; k++) step(1'b0, 1'b0, (k >= 2 * (S + 1) + 1) ? 4'b1000 : 4'b0001);

    // START held high: back-to-back scans with one idle cycle
    repeat (3 * L) step(1'b0, 1'b1, 4'($urandom));
    repeat (L + 3) step(1'b0, 1'b0, 4'($urandom));

`ifdef MUX_SCAN_CONT_EN
    cont_v = 1'b1;
    step(1'b0, 1'b1, 4'b0101);
    repeat (3 * (L + 1) + 2) step(1'b0, 1'b0, 4'b0101);
    cont_v = 1'b0;
    repeat (L + 4) step(1'b0, 1'b0, 4'b0101);
`endif

    repeat (400) begin
`ifdef MUX_SCAN_CONT_EN
      cont_v = ($urandom_range(0, 1) == 1);
`endif
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, 4'($urandom));
    end

`ifdef MUX_SCAN_CONT_EN
    cont_v = 1'b0;
`endif
    repeat (L + 6) step(1'b0, 1'b0, 4'($urandom));

    chk("scoreboard_drained", cyc, 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
